datapath_sequencer: RTL

- Multi-cycle command sequencer that owns the register-file/ALU `datapath` and drives all of its control ports.
- Accepts one command per transaction on a valid/ready interface: load-immediate, ALU op with write-back, register read, or compare.
- Steps the datapath through read, execute and write-back, then returns the result on a response handshake.
- Sits between the `datapath` instance and any upstream command source (test driver, future decode stage).

---
 rtl/datapath_sequencer_if.sv | 64 ++++++
 rtl/datapath_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
//
// Purpose:
//   Bundles the command and response handshakes of the datapath sequencer so
//   the upstream command source and the sequencer share one connection.
//
// Parameters:
//   Nloc   number of registers in the datapath; register address width is
//          $clog2(Nloc)
//   Dbits  data width of immediates and results
//
// Signals:
//   cmd_valid  command present (source -> sequencer)
//   cmd_ready  sequencer can accept a command (sequencer -> source)
//   cmd_op     00 LDI, 01 ALU, 10 RD, 11 CMP
//   cmd_rs     source A register
//   cmd_rt     source B register
//   cmd_rd     destination register
//   cmd_alufn  ALU function code handed through to the datapath
//   cmd_imm    immediate for LDI
//   rsp_valid  response present (sequencer -> consumer)
//   rsp_ready  consumer accepts the response (consumer -> sequencer)
//   rsp_data   result value
//   rsp_zero   result-is-zero flag
//
// Modports:
//   master  the command source / response consumer side
//   slave   the sequencer side
// -----------------------------------------------------------------------------
interface datapath_sequencer_if #(
  parameter int Nloc  = 32,
  parameter int Dbits = 32
);
  localparam int AW = $clog2(Nloc);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_rs;
  logic [AW-1:0]    cmd_rt;
  logic [AW-1:0]    cmd_rd;
  logic [4:0]       cmd_alufn;
  logic [Dbits-1:0] cmd_imm;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [Dbits-1:0] rsp_data;
  logic             rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_alufn, cmd_imm,
    input  cmd_ready,
    output rsp_ready,
    input  rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_alufn, cmd_imm,
    output cmd_ready,
    input  rsp_ready,
    output rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
//
// Purpose:
//   Multi-cycle command sequencer that owns the register-file/ALU datapath.
//   One command is accepted per transaction (LDI, ALU, RD, CMP); the datapath
//   is stepped through execute and write-back and the result is returned on a
//   response handshake. Commands advance IDLE -> EXEC -> WB -> RESP -> IDLE,
//   so a new command can issue at best every four cycles.
//
// Parameters:
//   Nloc   number of registers (address width $clog2(Nloc))
//   Dbits  register / ALU / immediate width
//   CNTW   width of the saturating retired-command counter
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   seq        command/response handshakes (datapath_sequencer_if.slave)
//   retired    count of completed responses, saturates at all-ones
//   RegWrite   register-file write enable, high only in the WB cycle
//   ReadAddr1  source A address to the datapath
//   ReadAddr2  source B address to the datapath
//   WriteAddr  destination address to the datapath
//   ALUFN      ALU function code to the datapath
//   WriteData  write-back value to the datapath
//   ReadData1  register A contents from the datapath
//   ReadData2  register B contents from the datapath (consumed by the ALU)
//   ALUResult  ALU output from the datapath
//   FlagZ      ALU zero flag from the datapath
//
// Configuration macro:
//   SEQ_R0_ZERO_EN  when defined, writes to register 0 are suppressed so r0
//                   reads as constant zero; the response still carries the
//                   computed value. When undefined r0 is an ordinary register.
// -----------------------------------------------------------------------------
module datapath_sequencer #(
  parameter int Nloc  = 32,
  parameter int Dbits = 32,
  parameter int CNTW  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  datapath_sequencer_if.slave     seq,
  output logic [CNTW-1:0]         retired,
  output logic                    RegWrite,
  output logic [$clog2(Nloc)-1:0] ReadAddr1,
  output logic [$clog2(Nloc)-1:0] ReadAddr2,
  output logic [$clog2(Nloc)-1:0] WriteAddr,
  output logic [4:0]              ALUFN,
  output logic [Dbits-1:0]        WriteData,
  input  logic [Dbits-1:0]        ReadData1,
  input  logic [Dbits-1:0]        ReadData2,
  input  logic [Dbits-1:0]        ALUResult,
  input  logic                    FlagZ
);

  localparam int AW = $clog2(Nloc);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10,
    RESP = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_ALU = 2'b01,
    OP_RD  = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    rs_q, rs_d;
  logic [AW-1:0]    rt_q, rt_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [4:0]       alufn_q, alufn_d;
  logic [Dbits-1:0] imm_q, imm_d;
  logic [Dbits-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             regWrite_q, regWrite_d;
  logic [CNTW-1:0]  retired_q, retired_d;
  logic             writesReg;
  logic             unusedReadData2;

  // ReadData2 only feeds the ALU inside the datapath; the sequencer never
  // looks at it directly, so it is folded into an intentionally unused bit.
  assign unusedReadData2 = ^ReadData2;

  // Decide whether the latched command owns the write-back slot. RD and CMP
  // still pass through WB so every command has the same latency.
`ifdef SEQ_R0_ZERO_EN
  assign writesReg = ((op_q == OP_LDI) || (op_q == OP_ALU)) && (rd_q != '0);
`else
  assign writesReg = (op_q == OP_LDI) || (op_q == OP_ALU);
`endif

  // Next-state and register-update logic. Everything holds by default; the
  // command fields only change on an accept, so the datapath addresses and
  // ALUFN stay put from one accept to the next. RegWrite is armed on the
  // EXEC->WB transition and falls back to 0 on the following edge.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    alufn_d    = alufn_q;
    imm_d      = imm_q;
    result_d   = result_q;
    zero_d     = zero_q;
    regWrite_d = 1'b0;
    retired_d  = retired_q;

    unique case (state_q)
      IDLE: begin
        if (seq.cmd_valid) begin
          op_d    = op_e'(seq.cmd_op);
          rs_d    = seq.cmd_rs;
          rt_d    = seq.cmd_rt;
          rd_d    = seq.cmd_rd;
          alufn_d = seq.cmd_alufn;
          imm_d   = seq.cmd_imm;
          state_d = EXEC;
        end
      end

      EXEC: begin
        // The datapath's combinational outputs are settled for the latched
        // addresses, so the result and its zero flag are captured here.
        case (op_q)
          OP_LDI: begin
            result_d = imm_q;
            zero_d   = (imm_q == '0);
          end
          OP_RD: begin
            result_d = ReadData1;
            zero_d   = (ReadData1 == '0);
          end
          default: begin
            result_d = ALUResult;
            zero_d   = FlagZ;
          end
        endcase
        regWrite_d = writesReg;
        state_d    = WB;
      end

      WB: begin
        state_d = RESP;
      end

      RESP: begin
        if (seq.rsp_ready) begin
          state_d = IDLE;
          if (retired_q != '1) begin
            retired_d = retired_q + CNTW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath-control registers. The asynchronous reset drops
  // RegWrite at once and discards any command in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= OP_LDI;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      alufn_q    <= '0;
      imm_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      regWrite_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      alufn_q    <= alufn_d;
      imm_q      <= imm_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      regWrite_q <= regWrite_d;
      retired_q  <= retired_d;
    end
  end

  assign seq.cmd_ready = (state_q == IDLE);
  assign seq.rsp_valid = (state_q == RESP);
  assign seq.rsp_data  = result_q;
  assign seq.rsp_zero  = zero_q;

  assign retired   = retired_q;
  assign RegWrite  = regWrite_q;
  assign ReadAddr1 = rs_q;
  assign ReadAddr2 = rt_q;
  assign WriteAddr = rd_q;
  assign ALUFN     = alufn_q;
  assign WriteData = result_q;

endmodule
